// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types and constants for the traffic phase scheduler
//
// Purpose: phase encodings, service-history encoding, light-head codes and
// default phase durations shared by the scheduler and its bench.
// Ports: none (package).

package traffic_pkg;

  // Phase encodings are visible on the debug `phase` output, so values are fixed.
  typedef enum logic [2:0] {
    PH_MAIN_GREEN  = 3'd0,
    PH_MAIN_YELLOW = 3'd1,
    PH_ALL_RED     = 3'd2,
    PH_SIDE_GREEN  = 3'd3,
    PH_SIDE_YELLOW = 3'd4,
    PH_PED_WALK    = 3'd5,
    PH_EMG_HOLD    = 3'd6
  } phase_e;

  // Which demand was served most recently out of ALL_RED.
  typedef enum logic {
    SERVED_SIDE = 1'b0,
    SERVED_PED  = 1'b1
  } served_e;

  // One-hot light-head codes.
  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  // Default timing, durations in seconds.
  localparam int DEF_CLK_PER_SEC = 50_000_000;
  localparam int DEF_T_MAIN_MIN  = 7;
  localparam int DEF_T_YEL       = 2;
  localparam int DEF_T_ALLRED    = 1;
  localparam int DEF_T_SIDE      = 5;
  localparam int DEF_T_PED       = 4;

endpackage

// File: rtl/traffic_phase_scheduler_sec_tick_gen.sv
// rtl/traffic_phase_scheduler_sec_tick_gen.sv - one-second tick prescaler
//
// Purpose: counts 0..CLK_PER_SEC-1 and flags `tick` during the last count.
// Clearing on `clr` lets every phase start with a full first second.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   clr  - synchronous clear of the prescaler
//   tick - high for one cycle per CLK_PER_SEC cycles

module sec_tick_gen #(
  parameter int CLK_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = $clog2(CLK_PER_SEC);
  localparam logic [W-1:0] LAST = W'(CLK_PER_SEC - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - demand-driven intersection phase scheduler
//
// Purpose: sequences main/side light heads and the pedestrian walk lamp,
// arbitrating between side-road demand, latched pedestrian demand and
// emergency preemption. Phase durations are counted in one-second ticks.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   side_req            - side-road vehicle present (level)
//   ped_req             - pedestrian button (any-width pulse)
//   emg_req             - emergency preempt (level)
//   light_main/side     - one-hot heads: 100 red, 010 yellow, 001 green
//   walk                - pedestrian walk lamp
//   ped_pending         - latched pedestrian request
//   phase               - current phase encoding (debug)

module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int CLK_PER_SEC = DEF_CLK_PER_SEC,
  parameter int T_MAIN_MIN  = DEF_T_MAIN_MIN,
  parameter int T_YEL       = DEF_T_YEL,
  parameter int T_ALLRED    = DEF_T_ALLRED,
  parameter int T_SIDE      = DEF_T_SIDE,
  parameter int T_PED       = DEF_T_PED
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       side_req,
  input  logic       ped_req,
  input  logic       emg_req,
  output logic [2:0] light_main,
  output logic [2:0] light_side,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  // Last second index of each timed phase.
  localparam logic [3:0] MAIN_LAST   = 4'(T_MAIN_MIN - 1);
  localparam logic [3:0] YEL_LAST    = 4'(T_YEL - 1);
  localparam logic [3:0] ALLRED_LAST = 4'(T_ALLRED - 1);
  localparam logic [3:0] SIDE_LAST   = 4'(T_SIDE - 1);
  localparam logic [3:0] PED_LAST    = 4'(T_PED - 1);

  phase_e     state, state_next;
  served_e    last_served;
  logic       from_main, from_main_next;
  logic [3:0] sec_cnt;
  logic       tick;
  logic       state_change;

  assign state_change = (state_next != state);

  sec_tick_gen #(
    .CLK_PER_SEC(CLK_PER_SEC)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (state_change),
    .tick(tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= PH_MAIN_GREEN;
      from_main   <= 1'b0;
      last_served <= SERVED_PED;
      sec_cnt     <= '0;
      ped_pending <= 1'b0;
    end else begin
      state     <= state_next;
      from_main <= from_main_next;

      // Saturate so a long idle MAIN_GREEN keeps its minimum-green condition met.
      if (state_change) begin
        sec_cnt <= '0;
      end else if (tick && (sec_cnt != 4'hF)) begin
        sec_cnt <= sec_cnt + 4'd1;
      end

      if (state_change && (state_next == PH_SIDE_GREEN)) begin
        last_served <= SERVED_SIDE;
      end else if (state_change && (state_next == PH_PED_WALK)) begin
        last_served <= SERVED_PED;
      end

      // Entering the walk phase consumes the request, even one arriving this cycle.
      if (state_change && (state_next == PH_PED_WALK)) begin
        ped_pending <= 1'b0;
      end else if (ped_req) begin
        ped_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next     = state;
    from_main_next = from_main;
    case (state)
      PH_MAIN_GREEN: begin
        if (emg_req) begin
          state_next = PH_EMG_HOLD;
        end else if (tick && (sec_cnt >= MAIN_LAST) && (side_req || ped_pending)) begin
          state_next = PH_MAIN_YELLOW;
        end
      end
      PH_MAIN_YELLOW: begin
        if (tick && (sec_cnt == YEL_LAST)) begin
          state_next     = PH_ALL_RED;
          from_main_next = 1'b1;
        end
      end
      PH_ALL_RED: begin
        if (tick && (sec_cnt == ALLRED_LAST)) begin
          if (emg_req) begin
            state_next = PH_EMG_HOLD;
          end else if (!from_main) begin
            state_next = PH_MAIN_GREEN;
          end else if (side_req && ped_pending) begin
            // Alternate between the two demands when both are waiting.
            state_next = (last_served == SERVED_PED) ? PH_SIDE_GREEN : PH_PED_WALK;
          end else if (side_req) begin
            state_next = PH_SIDE_GREEN;
          end else if (ped_pending) begin
            state_next = PH_PED_WALK;
          end else begin
            state_next = PH_MAIN_GREEN;
          end
        end
      end
      PH_SIDE_GREEN: begin
        if (emg_req || (tick && (sec_cnt == SIDE_LAST))) begin
          state_next = PH_SIDE_YELLOW;
        end
      end
      PH_SIDE_YELLOW: begin
        if (tick && (sec_cnt == YEL_LAST)) begin
          state_next     = PH_ALL_RED;
          from_main_next = 1'b0;
        end
      end
      PH_PED_WALK: begin
        // Preempted walk still clears through SIDE_YELLOW so the emergency
        // vehicle sees a full yellow + all-red before main goes green.
        if (emg_req) begin
          state_next = PH_SIDE_YELLOW;
        end else if (tick && (sec_cnt == PED_LAST)) begin
          state_next     = PH_ALL_RED;
          from_main_next = 1'b0;
        end
      end
      PH_EMG_HOLD: begin
        if (!emg_req) begin
          state_next = PH_MAIN_GREEN;
        end
      end
      default: begin
        state_next = PH_MAIN_GREEN;
      end
    endcase
  end

  always_comb begin
    light_main = LIGHT_RED;
    light_side = LIGHT_RED;
    walk       = 1'b0;
    case (state)
      PH_MAIN_GREEN,
      PH_EMG_HOLD:    light_main = LIGHT_GRN;
      PH_MAIN_YELLOW: light_main = LIGHT_YEL;
      PH_SIDE_GREEN:  light_side = LIGHT_GRN;
      PH_SIDE_YELLOW: light_side = LIGHT_YEL;
      PH_PED_WALK:    walk = 1'b1;
      default:        light_main = LIGHT_RED;
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb/tb_traffic_phase_scheduler.sv - directed self-checking bench for traffic_phase_scheduler

module tb_traffic_phase_scheduler;

  localparam logic [2:0] P_MG = 3'd0;
  localparam logic [2:0] P_MY = 3'd1;
  localparam logic [2:0] P_AR = 3'd2;
  localparam logic [2:0] P_SG = 3'd3;
  localparam logic [2:0] P_SY = 3'd4;
  localparam logic [2:0] P_PW = 3'd5;
  localparam logic [2:0] P_EH = 3'd6;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       side_req = 1'b0;
  logic       ped_req = 1'b0;
  logic       emg_req = 1'b0;
  logic [2:0] light_main;
  logic [2:0] light_side;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  traffic_phase_scheduler #(
    .CLK_PER_SEC(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .side_req   (side_req),
    .ped_req    (ped_req),
    .emg_req    (emg_req),
    .light_main (light_main),
    .light_side (light_side),
    .walk       (walk),
    .ped_pending(ped_pending),
    .phase      (phase)
  );

  // Leaves the bench at the negedge where rst drops (cycle 0 of MAIN_GREEN).
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Counts negedges the current phase is held, starting at its first negedge.
  task automatic measure(output int n, output logic [2:0] nxt);
    logic [2:0] cur;
    cur = phase;
    n = 0;
    while (phase == cur && n < 400) begin
      n++;
      @(negedge clk);
    end
    nxt = phase;
  endtask

  task automatic wait_for_phase(input logic [2:0] target, output bit ok);
    int n;
    n = 0;
    while (phase != target && n < 400) begin
      n++;
      @(negedge clk);
    end
    ok = (phase == target);
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (phase !== P_MG || light_main !== GRN || light_side !== RED || walk !== 1'b0 || ped_pending !== 1'b0) begin
      fails++;
      $display("FAIL reset: phase=%0d main=%b side=%b walk=%b ped=%b, required 0 001 100 0 0",
               phase, light_main, light_side, walk, ped_pending);
    end
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 100; i++) begin
      tests++;
      if (phase !== P_MG || light_main !== GRN || light_side !== RED || walk !== 1'b0) begin
        fails++;
        $display("FAIL idle cycle %0d: phase=%0d main=%b side=%b walk=%b, required 0 001 100 0",
                 i, phase, light_main, light_side, walk);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_side_cycle();
    int len_exp[6] = '{28, 8, 4, 20, 8, 4};
    logic [2:0] nxt_exp[6] = '{P_MY, P_AR, P_SG, P_SY, P_AR, P_MG};
    logic [2:0] main_exp[6] = '{GRN, YEL, RED, RED, RED, RED};
    logic [2:0] side_exp[6] = '{RED, RED, RED, GRN, YEL, RED};
    int n;
    logic [2:0] nxt;
    side_req = 1'b1;
    do_reset();
    for (int s = 0; s < 6; s++) begin
      tests++;
      if (light_main !== main_exp[s] || light_side !== side_exp[s]) begin
        fails++;
        $display("FAIL side_cycle lights step %0d: main=%b side=%b, required %b %b",
                 s, light_main, light_side, main_exp[s], side_exp[s]);
      end
      measure(n, nxt);
      tests++;
      if (n !== len_exp[s] || nxt !== nxt_exp[s]) begin
        fails++;
        $display("FAIL side_cycle step %0d: held %0d then phase %0d, required %0d then %0d",
                 s, n, nxt, len_exp[s], nxt_exp[s]);
      end
    end
    side_req = 1'b0;
  endtask

  task automatic test_pedestrian();
    int n;
    logic [2:0] nxt;
    do_reset();
    repeat (10) @(negedge clk);
    tests++;
    if (ped_pending !== 1'b0) begin
      fails++;
      $display("FAIL ped_before: ped_pending=%b, required 0", ped_pending);
    end
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    tests++;
    if (ped_pending !== 1'b1) begin
      fails++;
      $display("FAIL ped_latch: ped_pending=%b, required 1", ped_pending);
    end
    // Cycle 11 of a 28-cycle minimum green: 17 cycles remain.
    measure(n, nxt);
    tests++;
    if (n !== 17 || nxt !== P_MY) begin
      fails++;
      $display("FAIL ped_main_green: held %0d then %0d, required 17 then 1", n, nxt);
    end
    measure(n, nxt);
    measure(n, nxt);
    tests++;
    if (n !== 4 || nxt !== P_PW) begin
      fails++;
      $display("FAIL ped_all_red: held %0d then %0d, required 4 then 5", n, nxt);
    end
    tests++;
    if (walk !== 1'b1 || ped_pending !== 1'b0 || light_main !== RED || light_side !== RED) begin
      fails++;
      $display("FAIL ped_walk_entry: walk=%b ped=%b main=%b side=%b, required 1 0 100 100",
               walk, ped_pending, light_main, light_side);
    end
    measure(n, nxt);
    tests++;
    if (n !== 16 || nxt !== P_AR) begin
      fails++;
      $display("FAIL ped_walk_len: held %0d then %0d, required 16 then 2", n, nxt);
    end
    measure(n, nxt);
    tests++;
    if (n !== 4 || nxt !== P_MG || walk !== 1'b0) begin
      fails++;
      $display("FAIL ped_return: held %0d then %0d walk=%b, required 4 then 0 walk 0", n, nxt, walk);
    end
  endtask

  task automatic test_arbitration();
    logic [2:0] served_exp[4] = '{P_SG, P_PW, P_SG, P_PW};
    bit ok;
    int n;
    side_req = 1'b1;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      ped_req = 1'b1;
      @(negedge clk);
      ped_req = 1'b0;
      n = 0;
      while (phase != P_SG && phase != P_PW && n < 400) begin
        n++;
        @(negedge clk);
      end
      tests++;
      if (phase !== served_exp[r]) begin
        fails++;
        $display("FAIL arbitration round %0d: served phase %0d, required %0d", r, phase, served_exp[r]);
      end
      wait_for_phase(P_MG, ok);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL arbitration_return round %0d: phase %0d, required 0", r, phase);
      end
    end
    side_req = 1'b0;
  endtask

  task automatic test_emg_main();
    do_reset();
    repeat (3) @(negedge clk);
    emg_req = 1'b1;
    @(negedge clk);
    tests++;
    if (phase !== P_EH || light_main !== GRN || light_side !== RED) begin
      fails++;
      $display("FAIL emg_main_enter: phase=%0d main=%b side=%b, required 6 001 100", phase, light_main, light_side);
    end
    emg_req = 1'b0;
    @(negedge clk);
    tests++;
    if (phase !== P_MG) begin
      fails++;
      $display("FAIL emg_main_exit: phase=%0d, required 0", phase);
    end
  endtask

  task automatic test_preempt();
    bit ok;
    int n;
    logic [2:0] nxt;
    side_req = 1'b1;
    do_reset();
    wait_for_phase(P_SG, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL preempt_reach_side: phase=%0d, required 3", phase);
    end
    repeat (5) @(negedge clk);
    emg_req = 1'b1;
    @(negedge clk);
    tests++;
    if (phase !== P_SY) begin
      fails++;
      $display("FAIL preempt_side_yellow: phase=%0d, required 4", phase);
    end
    measure(n, nxt);
    tests++;
    if (n !== 8 || nxt !== P_AR) begin
      fails++;
      $display("FAIL preempt_yellow_len: held %0d then %0d, required 8 then 2", n, nxt);
    end
    measure(n, nxt);
    tests++;
    if (n !== 4 || nxt !== P_EH || light_main !== GRN || light_side !== RED) begin
      fails++;
      $display("FAIL preempt_hold: held %0d then %0d main=%b side=%b, required 4 then 6 001 100",
               n, nxt, light_main, light_side);
    end
    repeat (5) @(negedge clk);
    tests++;
    if (phase !== P_EH) begin
      fails++;
      $display("FAIL preempt_hold_stay: phase=%0d, required 6", phase);
    end
    emg_req = 1'b0;
    @(negedge clk);
    tests++;
    if (phase !== P_MG) begin
      fails++;
      $display("FAIL preempt_release: phase=%0d, required 0", phase);
    end
    measure(n, nxt);
    tests++;
    if (n !== 28 || nxt !== P_MY) begin
      fails++;
      $display("FAIL preempt_min_green: held %0d then %0d, required 28 then 1", n, nxt);
    end
    side_req = 1'b0;
  endtask

  task automatic test_async_reset();
    bit ok;
    side_req = 1'b1;
    do_reset();
    wait_for_phase(P_SY, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL async_reach_side_yellow: phase=%0d, required 4", phase);
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (phase !== P_MG || light_main !== GRN || light_side !== RED || walk !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: phase=%0d main=%b side=%b walk=%b, required 0 001 100 0",
               phase, light_main, light_side, walk);
    end
    #1;
    rst = 1'b0;
    side_req = 1'b0;
    @(negedge clk);
    tests++;
    if (phase !== P_MG) begin
      fails++;
      $display("FAIL async_resume: phase=%0d, required 0", phase);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle();
    test_side_cycle();
    test_pedestrian();
    test_arbitration();
    test_emg_main();
    test_preempt();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Demand-driven phase scheduler for a main-road / side-road intersection with a pedestrian crossing and emergency-vehicle preemption. It arbitrates between three requesters: the side-road vehicle sensor, the latched pedestrian button and the emergency preempt. It sequences the light heads through green/yellow/all-red phases using per-phase durations counted in seconds. The block sits between the sensor/button inputs and the light drivers, replacing fixed-cycle sequencing.

## Interface
- `CLK_PER_SEC`, default 50_000_000: clock cycles per one-second tick, ≥2.
- `T_MAIN_MIN`, default 7: minimum main green, in seconds.
- `T_YEL`, default 2: yellow duration, in seconds (both roads).
- `T_ALLRED`, default 1: all-red clearance, in seconds.
- `T_SIDE`, default 5: side green duration, in seconds.
- `T_PED`, default 4: pedestrian walk duration, in seconds. Every `T_*` is in the range 1..15.
- `clk`, in, 1: clock. The design has one clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `side_req`, in, 1: side-road vehicle present (level).
- `ped_req`, in, 1: pedestrian button (any-width pulse).
- `emg_req`, in, 1: emergency preempt (level).
- `light_main`, out, 3: main head, one-hot: 100 = red, 010 = yellow, 001 = green.
- `light_side`, out, 3: side head, same encoding.
- `walk`, out, 1: pedestrian walk lamp.
- `ped_pending`, out, 1: latched pedestrian request.
- `phase`, out, 3: current state encoding, for debug.

## Operation
- States and encodings:
  - MAIN_GREEN = 0, EMG_HOLD = 6: main 001, side 100.
  - MAIN_YELLOW = 1: main 010, side 100.
  - ALL_RED = 2, PED_WALK = 5: main 100, side 100. `walk` = 1 only in PED_WALK.
  - SIDE_GREEN = 3: main 100, side 001.
  - SIDE_YELLOW = 4: main 100, side 010.
- Seconds counter `sec_cnt` (4 bits): cleared on every state change; increments on each tick.
- Normal transitions, evaluated on a tick:
  - MAIN_GREEN → MAIN_YELLOW when `sec_cnt` ≥ T_MAIN_MIN−1 and (`side_req` or `ped_pending`). Otherwise MAIN_GREEN holds indefinitely.
  - MAIN_YELLOW → ALL_RED at `sec_cnt` == T_YEL−1. This sets `from_main`=1.
  - SIDE_GREEN → SIDE_YELLOW at `sec_cnt` == T_SIDE−1.
  - SIDE_YELLOW → ALL_RED at `sec_cnt` == T_YEL−1. This sets `from_main`=0.
  - PED_WALK → ALL_RED at `sec_cnt` == T_PED−1. This sets `from_main`=0.
- ALL_RED exit, at `sec_cnt` == T_ALLRED−1, first match wins:
  - `emg_req` → EMG_HOLD.
  - `from_main`=0 → MAIN_GREEN.
  - Both `side_req` and `ped_pending` set: serve the one not in `last_served`. `last_served` resets to PED, so side is served first after reset.
  - Only `side_req` set → SIDE_GREEN.
  - Only `ped_pending` set → PED_WALK.
  - Neither set → MAIN_GREEN.
  - Entering SIDE_GREEN or PED_WALK updates `last_served`.
- Preemption is tick-independent and acts on the next clock edge:
  - MAIN_GREEN with `emg_req` → EMG_HOLD.
  - SIDE_GREEN or PED_WALK with `emg_req` → SIDE_YELLOW.
  - MAIN_YELLOW, SIDE_YELLOW and ALL_RED always complete their duration.
  - EMG_HOLD with `emg_req`=0 → MAIN_GREEN, with the full minimum green restarting.
- `ped_pending`:
  - Set by `ped_req`=1 on any cycle.
  - Cleared on the edge that enters PED_WALK. Clear wins over a simultaneous set.
- Reset values: `phase`=MAIN_GREEN, `light_main`=001, `light_side`=100, `walk`=0, `ped_pending`=0, `from_main`=0, `last_served`=PED, prescaler=0, `sec_cnt`=0.

## Timing
- Tick:
  - Prescaler counts 0..CLK_PER_SEC−1 and pulses `tick` when at CLK_PER_SEC−1.
  - The prescaler clears on every state change.
  - Each timed state therefore lasts exactly T×CLK_PER_SEC cycles, including states entered by preemption.
- Outputs are a combinational decode of the state register. They are valid in the same cycle as `phase` and change only at clock edges.
- Request latency:
  - `side_req` is sampled only at ticks; the request must be present at the eligible tick.
  - A one-cycle `ped_req` is always captured.
- Async `rst` forces all outputs to their reset values immediately, without a clock edge, from any state. Operation resumes on the first edge after deassertion.

## Structure
- Shared package `traffic_pkg` holds:
  - State encodings.
  - Light constants: `LIGHT_RED`=3'b100, `LIGHT_YEL`=3'b010, `LIGHT_GRN`=3'b001.
  - Default durations.
- Sub-module `sec_tick_gen`:
  - Parameter CLK_PER_SEC.
  - Ports `clk`, `rst`, `clr`, `tick`.
  - Prescaler width $clog2(CLK_PER_SEC).
- Everything else (FSM, arbiter, `ped_pending` latch, output decode) lives in the top module.

## Test plan
All scenarios run with CLK_PER_SEC=4 and default durations.
- **Idle:** reset, no requests for 100 cycles → `phase` stays 0, `light_main`=001, `light_side`=100, `walk`=0.
- **Side cycle:** `side_req`=1 held from reset → MAIN_GREEN 28 cycles, MAIN_YELLOW 8, ALL_RED 4, SIDE_GREEN 20, SIDE_YELLOW 8, ALL_RED 4, then MAIN_GREEN.
- **Pedestrian:** one-cycle `ped_req` at cycle 10 → `ped_pending`=1 from cycle 11. Then PED_WALK with `walk`=1 for 16 cycles. `ped_pending`=0 from PED_WALK entry; ALL_RED, then MAIN_GREEN.
- **Arbitration:** `side_req` held and `ped_req` pulsed each round → served order SIDE, PED, SIDE, PED.
- **Preempt:** `emg_req` rises at cycle 5 of SIDE_GREEN → SIDE_YELLOW next edge, 8 cycles; ALL_RED 4 cycles; then EMG_HOLD (main 001). Drop `emg_req` → MAIN_GREEN next edge, then 28 cycles minimum.
- **Async reset:** `rst` pulsed between clock edges during SIDE_YELLOW → outputs read main 001, side 100, `walk` 0 before the next edge.
